// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for bin_to_bcd_seq.
// The master side requests a conversion; the slave side returns four BCD digits and status.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W = 14
);
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       val3;
    logic [3:0]       val2;
    logic [3:0]       val1;
    logic [3:0]       val0;

    modport master (
        output start, bin,
        input  busy, done, ovf, val3, val2, val1, val0
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, val3, val2, val1, val0
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional build macro OVF_SATURATE_EN: an overflowing value shows as 9999 instead of value mod 10000.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one adjust-and-shift step per cycle, BIN_W steps in total
// DONE  | scratch is complete; results latched on leaving, start may reload at once
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input logic            clk,
    input logic            rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [BIN_W-1:0] shreg;
    logic [19:0]      scratch;
    logic [18:0]      scratch_adj;
    logic [CNT_W-1:0] cnt;
    logic             load, shift_en, latch;
    logic             done_q, ovf_q;
    logic [3:0]       val3_q, val2_q, val1_q, val0_q;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Bit 19 always leaves on the shift, so the top digit only needs its low three bits adjusted.
    always_comb begin
        scratch_adj          = '0;
        scratch_adj[3:0]     = add3(scratch[3:0]);
        scratch_adj[7:4]     = add3(scratch[7:4]);
        scratch_adj[11:8]    = add3(scratch[11:8]);
        scratch_adj[15:12]   = add3(scratch[15:12]);
        scratch_adj[18:16]   = (scratch[18:16] >= 3'd5) ? scratch[18:16] + 3'd3 : scratch[18:16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
            DONE: begin
                latch = 1'b1;
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else if (load) begin
            shreg   <= bus.bin;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
        end else if (shift_en) begin
            scratch <= {scratch_adj, shreg[BIN_W-1]};
            shreg   <= shreg << 1;
            cnt     <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            val3_q <= '0;
            val2_q <= '0;
            val1_q <= '0;
            val0_q <= '0;
        end else begin
            done_q <= latch;
            if (latch) begin
                ovf_q <= |scratch[19:16];
`ifdef OVF_SATURATE_EN
                if (|scratch[19:16]) begin
                    val3_q <= 4'd9;
                    val2_q <= 4'd9;
                    val1_q <= 4'd9;
                    val0_q <= 4'd9;
                end else begin
                    val3_q <= scratch[15:12];
                    val2_q <= scratch[11:8];
                    val1_q <= scratch[7:4];
                    val0_q <= scratch[3:0];
                end
`else
                val3_q <= scratch[15:12];
                val2_q <= scratch[11:8];
                val1_q <= scratch[7:4];
                val0_q <= scratch[3:0];
`endif
            end
        end
    end

    // busy stays up through the cycle that presents done, so it falls one cycle after the pulse.
    assign bus.busy = (state != IDLE) || done_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.val3 = val3_q;
    assign bus.val2 = val2_q;
    assign bus.val1 = val1_q;
    assign bus.val0 = val0_q;
endmodule
